data_path: RTL and testbench

DATA_PATH -- requirements
Module: data_path

---
 rtl/data_path.sv | 178 +++++++++++++++++
 tb/tb_data_path.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_path.sv
// ============================================================================
// Module  : data_path
// Brief   : K&S processor datapath: PC, IR, decode, 4x16 register file, ALU
//           and registered condition flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_BRANCH = 4'd1,
        I_BZERO  = 4'd2,
        I_BNZERO = 4'd3,
        I_BNEG   = 4'd4,
        I_BNNEG  = 4'd5,
        I_BOV    = 4'd6,
        I_BNOV   = 4'd7,
        I_LOAD   = 4'd8,
        I_STORE  = 4'd9,
        I_MOVE   = 4'd10,
        I_ADD    = 4'd11,
        I_SUB    = 4'd12,
        I_AND    = 4'd13,
        I_OR     = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;
endpackage

module data_path
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic                    flags_reg_enable,
    input  logic [1:0]              operation,
    input  logic                    ram_write_enable,
    input  logic [15:0]             data_in,
    output logic [4:0]              ram_addr,
    output logic                    ram_we,
    output logic [15:0]             data_out,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow
);

    localparam logic [1:0] C_OP_ADD = 2'b00;
    localparam logic [1:0] C_OP_SUB = 2'b01;
    localparam logic [1:0] C_OP_AND = 2'b10;

    logic [4:0]  r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_regs [4];

    logic [1:0]  w_rd_a_addr;
    logic [1:0]  w_rd_b_addr;
    logic [1:0]  w_wr_addr;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [15:0] w_result;
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic        w_carry;
    logic        w_ovf;
    logic [15:0] w_wr_data;

    assign ram_we   = ram_write_enable;
    assign ram_addr = addr_sel ? r_ir[4:0] : r_pc;
    assign data_out = r_regs[r_ir[6:5]];

    always_comb begin
        decoded_instruction = I_NOP;
        case (r_ir[15:8])
            8'h01:   decoded_instruction = I_BRANCH;
            8'h02:   decoded_instruction = I_BZERO;
            8'h03:   decoded_instruction = I_BNZERO;
            8'h04:   decoded_instruction = I_BNEG;
            8'h05:   decoded_instruction = I_BNNEG;
            8'h06:   decoded_instruction = I_BOV;
            8'h07:   decoded_instruction = I_BNOV;
            8'h81:   decoded_instruction = I_LOAD;
            8'h82:   decoded_instruction = I_STORE;
            8'h91:   decoded_instruction = I_MOVE;
            8'hA1:   decoded_instruction = I_ADD;
            8'hA2:   decoded_instruction = I_SUB;
            8'hA3:   decoded_instruction = I_AND;
            8'hA4:   decoded_instruction = I_OR;
            8'hFF:   decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    // MOVE reads its single source on both ports so the ALU OR acts as a copy.
    always_comb begin
        w_rd_a_addr = r_ir[3:2];
        w_rd_b_addr = r_ir[1:0];
        w_wr_addr   = r_ir[5:4];
        if (decoded_instruction == I_MOVE) begin
            w_rd_a_addr = r_ir[1:0];
            w_wr_addr   = r_ir[3:2];
        end else if (decoded_instruction == I_LOAD) begin
            w_wr_addr   = r_ir[6:5];
        end
    end

    assign w_a    = r_regs[w_rd_a_addr];
    assign w_b    = r_regs[w_rd_b_addr];
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

    always_comb begin
        w_result = w_a | w_b;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (operation)
            C_OP_ADD: begin
                w_result = w_sum[15:0];
                w_carry  = w_sum[16];
                w_ovf    = (w_a[15] == w_b[15]) && (w_sum[15] != w_a[15]);
            end
            C_OP_SUB: begin
                w_result = w_diff[15:0];
                w_carry  = w_diff[16];
                w_ovf    = (w_a[15] != w_b[15]) && (w_diff[15] != w_a[15]);
            end
            C_OP_AND: w_result = w_a & w_b;
            default:  w_result = w_a | w_b;
        endcase
    end

    assign w_wr_data = c_sel ? data_in : w_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= 5'd0;
            r_ir <= 16'd0;
        end else begin
            if (ir_enable)
                r_ir <= data_in;
            if (pc_enable)
                r_pc <= branch ? r_ir[4:0] : r_pc + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                r_regs[i] <= 16'd0;
        end else if (write_reg_enable) begin
            r_regs[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= (w_result == 16'd0);
            neg_op            <= w_result[15];
            unsigned_overflow <= w_carry;
            signed_overflow   <= w_ovf;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_path.sv
// ============================================================================
// Module  : tb_data_path
// Brief   : Directed self-checking bench for data_path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_path;
    import k_and_s_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch, pc_enable, ir_enable, write_reg_enable;
    logic        addr_sel, c_sel, flags_reg_enable, ram_write_enable;
    logic [1:0]  operation;
    logic [15:0] data_in;
    logic [4:0]  ram_addr;
    logic        ram_we;
    logic [15:0] data_out;
    decoded_instruction_type decoded_instruction;
    logic        zero_op, neg_op, unsigned_overflow, signed_overflow;

    int checks   = 0;
    int failures = 0;

    data_path dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .write_reg_enable    (write_reg_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .flags_reg_enable    (flags_reg_enable),
        .operation           (operation),
        .ram_write_enable    (ram_write_enable),
        .data_in             (data_in),
        .ram_addr            (ram_addr),
        .ram_we              (ram_we),
        .data_out            (data_out),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp);
        check(tag, {12'd0, zero_op, neg_op, unsigned_overflow, signed_overflow}, {12'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
        addr_sel = 0; c_sel = 0; flags_reg_enable = 0; ram_write_enable = 0;
        operation = 2'b00;
    endtask

    task automatic load_ir(input logic [15:0] w);
        idle();
        data_in = w; ir_enable = 1;
        tick();
        idle();
    endtask

    // LOAD a constant into register r through the RAM read-data path.
    task automatic write_reg(input logic [1:0] r, input logic [15:0] v);
        load_ir(16'h8100 | (16'(r) << 5));
        data_in = v; c_sel = 1; write_reg_enable = 1;
        tick();
        idle();
    endtask

    task automatic read_reg(input string tag, input logic [1:0] r, input logic [15:0] exp);
        load_ir(16'h0000 | (16'(r) << 5));
        check(tag, data_out, exp);
    endtask

    task automatic alu_op(input logic [15:0] ir, input logic [1:0] op, input logic fl);
        load_ir(ir);
        operation = op; write_reg_enable = 1; flags_reg_enable = fl; c_sel = 0;
        tick();
        idle();
    endtask

    initial begin
        idle();
        data_in = 16'h0;
        rst_n = 0;
        #12;
        check("rst_ram_addr", {11'd0, ram_addr}, 16'd0);
        check("rst_decode", {12'd0, decoded_instruction}, {12'd0, I_NOP});
        check("rst_data_out", data_out, 16'h0);
        check_flags("rst_flags", 4'b0000);
        @(negedge clk);
        rst_n = 1;
        #1;

        // Fetch
        data_in = 16'h8123; ir_enable = 1; pc_enable = 1;
        tick();
        idle();
        check("fetch_decode", {12'd0, decoded_instruction}, {12'd0, I_LOAD});
        check("fetch_pc", {11'd0, ram_addr}, 16'd1);
        addr_sel = 1; #1;
        check("fetch_ir_addr", {11'd0, ram_addr}, 16'd3);
        ram_write_enable = 1; #1;
        check("ram_we_pass", {15'd0, ram_we}, 16'd1);
        idle();

        // LOAD BEEF into R2
        load_ir(16'h8143);
        addr_sel = 1; c_sel = 1; data_in = 16'hBEEF; write_reg_enable = 1; #1;
        check("load_addr", {11'd0, ram_addr}, 16'd3);
        tick();
        idle();
        check("load_r2", data_out, 16'hBEEF);

        write_reg(2'd1, 16'h7FFF);
        read_reg("r1_7fff", 2'd1, 16'h7FFF);

        // Old value visible before the write edge, new value after
        load_ir(16'h8140);
        data_in = 16'h0001; c_sel = 1; write_reg_enable = 1; #1;
        check("rd_before_wr", data_out, 16'hBEEF);
        tick();
        idle();
        check("rd_after_wr", data_out, 16'h0001);

        // ADD R0 = R1 + R2 = 7FFF + 1
        alu_op(16'hA106, 2'b00, 1'b1);
        check_flags("add_flags", 4'b0101);
        read_reg("add_r0", 2'd0, 16'h8000);

        // SUB R3 = R1 - R2 = 0 - 1
        write_reg(2'd1, 16'h0000);
        alu_op(16'hA236, 2'b01, 1'b1);
        check_flags("sub_flags", 4'b0110);
        read_reg("sub_r3", 2'd3, 16'hFFFF);

        // AND R0 = R3 & R2
        alu_op(16'hA30E, 2'b10, 1'b1);
        check_flags("and_flags", 4'b0000);
        read_reg("and_r0", 2'd0, 16'h0001);

        // ADD R1 = R3 + R2 = FFFF + 1 -> zero with carry
        alu_op(16'hA11E, 2'b00, 1'b1);
        check_flags("add_zero_flags", 4'b1010);
        read_reg("add_zero_r1", 2'd1, 16'h0000);

        // MOVE R0 <- R3 with flags held
        alu_op(16'h9103, 2'b11, 1'b0);
        check_flags("flags_held", 4'b1010);
        read_reg("move_r0", 2'd0, 16'hFFFF);
        read_reg("move_r3_kept", 2'd3, 16'hFFFF);

        // PC wrap: PC is 1 here
        pc_enable = 1;
        for (int i = 0; i < 30; i++) tick();
        idle();
        check("pc_31", {11'd0, ram_addr}, 16'd31);
        pc_enable = 1;
        tick();
        idle();
        check("pc_wrap", {11'd0, ram_addr}, 16'd0);

        load_ir(16'h0115);
        check("branch_decode", {12'd0, decoded_instruction}, {12'd0, I_BRANCH});
        pc_enable = 1; branch = 1;
        tick();
        idle();
        check("pc_branch", {11'd0, ram_addr}, 16'd21);

        // No enables: nothing moves
        data_in = 16'h5555;
        tick(); tick();
        check("hold_pc", {11'd0, ram_addr}, 16'd21);
        check("hold_decode", {12'd0, decoded_instruction}, {12'd0, I_BRANCH});
        check_flags("hold_flags", 4'b1010);

        // Asynchronous reset during a pending register write
        load_ir(16'h8100);
        check("pre_rst_r0", data_out, 16'hFFFF);
        data_in = 16'h1234; c_sel = 1; write_reg_enable = 1;
        #2;
        rst_n = 0;
        #1;
        check("arst_r0", data_out, 16'h0000);
        check("arst_pc", {11'd0, ram_addr}, 16'd0);
        check_flags("arst_flags", 4'b0000);
        check("arst_decode", {12'd0, decoded_instruction}, {12'd0, I_NOP});
        @(posedge clk); #1;
        check("arst_hold_r0", data_out, 16'h0000);
        idle();
        @(negedge clk);
        rst_n = 1;
        tick();
        check("post_rst_pc", {11'd0, ram_addr}, 16'd0);
        read_reg("post_rst_r3", 2'd3, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
